// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader for an 18-bit instruction memory.
//
// Accepts a valid/ready byte stream and writes instruction words into a program memory.
// The CPU is held (cpu_run_o=0) while loading and is released once the image is written.
//
// Stream format: one count byte N (1..2**AW), then N words of three bytes each.
// Each word is sent as {000000,d[17:16]}, d[15:8], d[7:0]. When the checksum option
// is built in, one XOR checksum byte follows the last word.
//
// Build option: define LOADER_CHECKSUM_EN to add the checksum state and accumulator.
//
// Ports:
//   clk_i       system clock, posedge
//   reset_ni    asynchronous active-low reset
//   start_i     one-cycle pulse: begin a new load (honoured only in idle/done/error)
//   in_valid_i  byte-stream valid
//   in_data_i   byte-stream data
//   in_ready_o  loader accepts a byte this cycle (depends on state only)
//   wr_en_o     program memory write strobe
//   wr_addr_o   program memory write address
//   wr_data_o   program memory write data
//   cpu_run_o   1 = CPU may execute
//   done_o      last load completed without error
//   err_o       last load aborted
module prog_loader #(
  parameter int unsigned AW = 4,
  parameter int unsigned IW = 18
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          start_i,
  input  logic          in_valid_i,
  input  logic [7:0]    in_data_i,
  output logic          in_ready_o,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [IW-1:0] wr_data_o,
  output logic          cpu_run_o,
  output logic          done_o,
  output logic          err_o
);

  localparam logic [3:0] StIdle  = 4'd0;
  localparam logic [3:0] StCount = 4'd1;
  localparam logic [3:0] StB0    = 4'd2;
  localparam logic [3:0] StB1    = 4'd3;
  localparam logic [3:0] StB2    = 4'd4;
  localparam logic [3:0] StWrite = 4'd5;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [3:0] StChk   = 4'd6;
`endif
  localparam logic [3:0] StDone  = 4'd7;
  localparam logic [3:0] StErr   = 4'd8;

  // Word counter needs one extra bit so a full image of 2**AW words is representable.
  localparam int unsigned CntW = AW + 1;

  logic [3:0]      state_q, state_d;
  logic [CntW-1:0] n_q, n_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [IW-1:0]   data_q, data_d;
  logic            in_ready_q, in_ready_d;
  logic            wr_en_q, wr_en_d;
  logic            cpu_run_q, cpu_run_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            xfer;
  logic            count_bad;
  logic            last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      acc_q, acc_d;
`endif

  assign xfer      = in_valid_i & in_ready_q;
  // 9-bit compare keeps 2**AW representable for AW up to 8.
  assign count_bad = (in_data_i == 8'd0) || (9'(in_data_i) > 9'(2**AW));
  assign last_word = ((cnt_q + CntW'(1)) == n_q);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef LOADER_CHECKSUM_EN
    acc_d   = acc_q;
    if (xfer) acc_d = acc_q ^ in_data_i;
`endif
    case (state_q)
      StIdle, StDone, StErr: begin
        if (start_i) begin
          state_d = StCount;
          cnt_d   = '0;
          addr_d  = '0;
`ifdef LOADER_CHECKSUM_EN
          acc_d   = 8'd0;
`endif
        end
      end
      StCount: begin
        if (xfer) begin
          if (count_bad) begin
            state_d = StErr;
          end else begin
            n_d     = CntW'(in_data_i);
            state_d = StB0;
          end
        end
      end
      StB0: begin
        if (xfer) begin
          if (in_data_i[7:2] != 6'd0) begin
            state_d = StErr;
          end else begin
            data_d[17:16] = in_data_i[1:0];
            state_d       = StB1;
          end
        end
      end
      StB1: begin
        if (xfer) begin
          data_d[15:8] = in_data_i;
          state_d      = StB2;
        end
      end
      StB2: begin
        if (xfer) begin
          data_d[7:0] = in_data_i;
          state_d     = StWrite;
        end
      end
      StWrite: begin
        addr_d = addr_q + AW'(1);
        cnt_d  = cnt_q + CntW'(1);
        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = StChk;
`else
          state_d = StDone;
`endif
        end else begin
          state_d = StB0;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StChk: begin
        if (xfer) state_d = (in_data_i == acc_q) ? StDone : StErr;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered decodes of the next state, so they are glitch-free.
  always_comb begin
    in_ready_d = (state_d == StCount) || (state_d == StB0) || (state_d == StB1) ||
`ifdef LOADER_CHECKSUM_EN
                 (state_d == StChk) ||
`endif
                 (state_d == StB2);
    wr_en_d    = (state_d == StWrite);
    done_d     = (state_d == StDone);
    err_d      = (state_d == StErr);
    cpu_run_d  = (state_d == StDone);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= StIdle;
      n_q        <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      cpu_run_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      acc_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      cpu_run_q  <= cpu_run_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef LOADER_CHECKSUM_EN
      acc_q      <= acc_d;
`endif
    end
  end

  assign in_ready_o = in_ready_q;
  assign wr_en_o    = wr_en_q;
  assign wr_addr_o  = addr_q;
  assign wr_data_o  = data_q;
  assign cpu_run_o  = cpu_run_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: self-checking bench for prog_loader (AW=4).
// A stream-level model parses each byte stream into the list of memory writes and the
// final outcome; a compare process checks every write strobe against that list.
module tb_prog_loader;

  localparam int unsigned AW = 4;
  localparam int unsigned Cap = 1 << AW;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [17:0]   wr_data;
  logic          cpu_run;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;

  logic [7:0]    stim_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [17:0]   exp_data_q[$];
  logic [AW-1:0] log_addr_q[$];
  logic [17:0]   log_data_q[$];

  prog_loader #(.AW(AW), .IW(18)) dut (
    .clk_i      (clk),
    .reset_ni   (reset_n),
    .start_i    (start),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_ready_o (in_ready),
    .wr_en_o    (wr_en),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .cpu_run_o  (cpu_run),
    .done_o     (done),
    .err_o      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Compare process: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (reset_n && wr_en) begin
      log_addr_q.push_back(wr_addr);
      log_data_q.push_back(wr_data);
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%0h@%0h required=none", wr_data, wr_addr);
      end else begin
        chk("write_addr", 32'(wr_addr), 32'(exp_addr_q.pop_front()));
        chk("write_data", 32'(wr_data), 32'(exp_data_q.pop_front()));
      end
    end
    if (reset_n && (in_ready || wr_en)) chk("cpu_held_while_loading", 32'(cpu_run), 32'd0);
  end

  // Parse stim_q as the loader would: queue expected writes, report bytes consumed,
  // final success and number of words written.
  task automatic model(output int consumed, output bit ok, output int nwr);
    logic [7:0] n, b0, b1, b2, x;
    int  p;
    bit  bad;
    p = 0; x = 8'd0; bad = 0; nwr = 0;
    n = stim_q[0];
    x = x ^ n;
    p = 1;
    if (n == 8'd0 || int'(n) > Cap) bad = 1;
    for (int w = 0; w < int'(n) && !bad; w++) begin
      b0 = stim_q[p];
      p++;
      if (b0[7:2] != 6'd0) begin
        bad = 1;
      end else begin
        b1 = stim_q[p];
        b2 = stim_q[p+1];
        p += 2;
        x = x ^ b0 ^ b1 ^ b2;
        exp_addr_q.push_back(AW'(w));
        exp_data_q.push_back({b0[1:0], b1, b2});
        nwr++;
      end
    end
`ifdef LOADER_CHECKSUM_EN
    if (!bad) begin
      ok = (stim_q[p] == x);
      p++;
    end else begin
      ok = 0;
    end
`else
    ok = !bad;
`endif
    consumed = p;
  endtask

  task automatic add_csum();
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'd0;
    foreach (stim_q[i]) x = x ^ stim_q[i];
    stim_q.push_back(x);
`endif
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_clears_done", 32'(done), 32'd0);
    chk("start_clears_err", 32'(err), 32'd0);
    chk("start_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    int k;
    @(negedge clk);
    if (gaps) begin
      k = $urandom_range(0, 2);
      if (k != 0) begin
        in_valid = 1'b0;
        repeat (k) @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 required=1 byte=%0h", b);
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic run_load(input string name, input bit gaps);
    int  consumed, nwr, t;
    bit  ok;
    log_addr_q.delete();
    log_data_q.delete();
    model(consumed, ok, nwr);
    do_start();
    for (int i = 0; i < consumed; i++) send_byte(stim_q[i], gaps);
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (!(done || err) && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_done"}, 32'(done), 32'(ok));
    chk({name, "_err"}, 32'(err), 32'(!ok));
    chk({name, "_cpu_run"}, 32'(cpu_run), 32'(ok));
    chk({name, "_ready_low"}, 32'(in_ready), 32'd0);
    chk({name, "_writes_pending"}, 32'(exp_addr_q.size()), 32'd0);
    chk({name, "_final_addr"}, 32'(wr_addr), 32'(nwr % Cap));
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ready"}, 32'(in_ready), 32'd0);
    chk({name, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({name, "_addr"}, 32'(wr_addr), 32'd0);
    chk({name, "_data"}, 32'(wr_data), 32'd0);
    chk({name, "_flags"}, {29'd0, cpu_run, done, err}, 32'd0);
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;

    // 1: reset mid-word discards the partial word.
    log_addr_q.delete();
    do_start();
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    send_byte(8'hFF, 0);
    #2 reset_n = 1'b0;
    in_valid = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("after_reset");
    chk("reset_no_write", 32'(log_addr_q.size()), 32'd0);

    // 2: two-word image.
    stim_q = '{8'h02, 8'h03, 8'hFF, 8'hFF, 8'h00, 8'h12, 8'h34};
    add_csum();
    run_load("two_words", 0);
    chk("two_words_count", 32'(log_data_q.size()), 32'd2);
    if (log_data_q.size() == 2) begin
      chk("two_words_w0", 32'(log_data_q[0]), 32'h3FFFF);
      chk("two_words_w1", 32'(log_data_q[1]), 32'h01234);
      chk("two_words_a1", 32'(log_addr_q[1]), 32'd1);
    end

    // 3: bad word counts.
    stim_q = '{8'h00};
    run_load("count_zero", 0);
    stim_q = '{8'h11};
    run_load("count_17", 0);

    // 4: nonzero upper bits in first word byte.
    stim_q = '{8'h01, 8'h04, 8'h00, 8'h00};
    run_load("b0_bad", 0);
    chk("b0_bad_no_write", 32'(log_data_q.size()), 32'd0);

    // 5: full 16-word image with random valid gaps.
    stim_q.delete();
    stim_q.push_back(8'h10);
    for (int w = 0; w < 16; w++) begin
      stim_q.push_back(8'(w % 4));
      stim_q.push_back(8'(w * 17));
      stim_q.push_back(~8'(w));
    end
    add_csum();
    run_load("full_image", 1);
    chk("full_image_count", 32'(log_addr_q.size()), 32'd16);
    if (log_addr_q.size() == 16) begin
      chk("full_image_last_addr", 32'(log_addr_q[15]), 32'd15);
      chk("full_image_last_data", 32'(log_data_q[15]), 32'h3FFF0);
    end

`ifdef LOADER_CHECKSUM_EN
    // 6: checksum accept and reject.
    stim_q = '{8'h01, 8'h00, 8'h00, 8'h05, 8'h04};
    run_load("csum_good", 0);
    chk("csum_good_done_lit", 32'(done), 32'd1);
    stim_q = '{8'h01, 8'h00, 8'h00, 8'h05, 8'h05};
    run_load("csum_bad", 0);
    chk("csum_bad_err_lit", 32'(err), 32'd1);
    chk("csum_bad_count", 32'(log_data_q.size()), 32'd1);
    if (log_data_q.size() == 1) chk("csum_bad_w0", 32'(log_data_q[0]), 32'h00005);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
